jelly_axi4_read_arbiter2: RTL
=============================

Name: jelly_axi4_read_arbiter2

Overview:
- Shares one AXI4 read port (64-bit data, 6-bit ID memory port of the PS/DDR subsystem) between two read masters, e.g. a video DMA and a CNN weight fetcher.
- Round-robin AR arbitration; the master index is tagged onto the ID MSB.
- R beats are routed back by that MSB.
- Per-master outstanding-burst limit prevents one requester from monopolising the memory.

Parameters:
- S_ID_WIDTH, 5, slave-side ID width; m_arid/m_rid are S_ID_WIDTH+1 bits.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 64, read data width.
- MAX_OUTSTANDING, 4, max accepted-but-unfinished bursts per master (1..15).

Ports:
- clk  in  1  single clock for all channels.
- reset  in  1  synchronous, active-high.
- s{0,1}_arid  in  S_ID_WIDTH  request ID.
- s{0,1}_araddr  in  ADDR_WIDTH  address.
- s{0,1}_arlen  in  8  burst length-1.
- s{0,1}_arsize  in  3  beat size.
- s{0,1}_arburst  in  2  burst type.
- s{0,1}_arlock  in  1  lock.
- s{0,1}_arcache  in  4  cache.
- s{0,1}_arprot  in  3  prot.
- s{0,1}_arqos  in  4  qos.
- s{0,1}_arvalid  in  1.
- s{0,1}_arready  out  1.
- s{0,1}_rid  out  S_ID_WIDTH.
- s{0,1}_rdata  out  DATA_WIDTH.
- s{0,1}_rresp  out  2.
- s{0,1}_rlast  out  1.
- s{0,1}_rvalid  out  1.
- s{0,1}_rready  in  1.
- m_arid  out  S_ID_WIDTH+1  {master index, s_arid}.
- m_araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos  out  as slave side.
- m_arvalid  out  1.
- m_arready  in  1.
- m_rid  in  S_ID_WIDTH+1.
- m_rdata  in  DATA_WIDTH.
- m_rresp  in  2.
- m_rlast  in  1.
- m_rvalid  in  1.
- m_rready  out  1.

Behaviour:
- Reset values: m_arvalid=0, s{0,1}_arready=0, all m_ar payload regs=0, outstanding counters=0, rr pointer last_grant=1 (so master 0 wins first).
- AR output register (one entry) is "free" when m_arvalid=0 or (m_arvalid & m_arready).
- Eligibility: master k is eligible when sk_arvalid=1 and cnt_k<MAX_OUTSTANDING.
- Grant (combinational, every cycle register is free):
  - only one eligible -> that one;
  - both eligible -> the one != last_grant;
  - none -> no grant.
- sk_arready=1 only for the granted master in that cycle; sk_arready=0 whenever register not free or master not eligible.
- On grant k (sk_arvalid & sk_arready):
  - next cycle m_arvalid=1, m_arid={k, sk_arid}, payload copied;
  - last_grant<=k;
  - cnt_k increments.
- Latency: s-side AR handshake in cycle N -> m_arvalid in N+1.
- Back-to-back bursts: new grant in same cycle as m_arready keeps m_arvalid=1 with new payload; throughput 1 AR/cycle.
- m_arvalid and payload held stable until m_arready (AXI rule); no payload change while m_arvalid & !m_arready.
- R path (combinational, zero latency); k = m_rid[S_ID_WIDTH]:
  - sk_rvalid = m_rvalid & (m_rid[S_ID_WIDTH]==k);
  - s_rid/rdata/rresp/rlast = m_r* (ID MSB stripped), broadcast to both;
  - m_rready = s(k)_rready.
- cnt_k decrements on m_rvalid & m_rready & m_rlast for k.
- Simultaneous AR accept and rlast completion for the same master -> cnt_k unchanged.
- cnt_k never wraps:
  - increment blocked at MAX_OUTSTANDING by eligibility;
  - rlast arriving with cnt_k=0 is a protocol error; cnt stays 0 (saturate).
- Reset mid-operation: all state returns to reset values next edge; in-flight bursts are abandoned; the downstream slave is reset by the same system reset.
- No combinational path from sk_arvalid to m_arvalid; arready depends on sk_arvalid, counters, last_grant, m_arvalid, m_arready.

Test Plan:
- Single master: s0 AR addr 0x1000 len 7 id 3 -> m_arvalid next cycle, m_arid=0x03, 8 beats with m_rid=0x03 appear only on s0_r*, cnt0 back to 0 after rlast.
- Contention: s0 and s1 both valid continuously with m_arready=1 -> grants alternate s0,s1,s0,s1; s1 id 5 appears as m_arid=0x25.
- Backpressure: m_arready=0 for 10 cycles while s0/s1 valid -> m_arvalid and payload stable, both s_arready=0; release -> transfer completes, next grant same cycle.
- Outstanding limit: MAX_OUTSTANDING=4, s0 issues 5 ARs, no R returned -> 4 accepted, 5th s0_arready=0 while s1 still granted; one s0 rlast -> 5th accepted next cycle.
- R routing/backpressure: interleaved R beats id 0x01 and 0x21, s1_rready=0 -> m_rready=0 on 0x21 beats only, s0 beats pass unaffected.
- Reset mid-burst: assert reset with cnt0=2 and m_arvalid=1 -> next cycle m_arvalid=0, counters 0, first post-reset grant to s0.

Source files
------------

// File: rtl/jelly_axi4_read_arbiter2_if.sv
// AXI4 read-channel bundle (AR + R) shared by both requesters and the memory port.
interface jelly_axi4_read_arbiter2_if #(
    parameter int ID_WIDTH   = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) ();

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    // Issuer of read requests (drives AR, accepts R).
    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    // Responder to read requests (accepts AR, drives R).
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/jelly_axi4_read_arbiter2.sv
// Two-requester AXI4 read arbiter: round-robin AR grant with a registered AR
// stage, requester index tagged on the ID MSB, R beats steered back by that MSB,
// and a per-requester cap on accepted-but-unfinished bursts.
module jelly_axi4_read_arbiter2 #(
    parameter int S_ID_WIDTH      = 5,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    jelly_axi4_read_arbiter2_if.slave    s0,
    jelly_axi4_read_arbiter2_if.slave    s1,
    jelly_axi4_read_arbiter2_if.master   m
);

    // Counters hold 0..15, enough for any legal MAX_OUTSTANDING.
    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic                   arvalid_q,    arvalid_d;
    logic [S_ID_WIDTH:0]    arid_q,       arid_d;
    logic [ADDR_WIDTH-1:0]  araddr_q,     araddr_d;
    logic [7:0]             arlen_q,      arlen_d;
    logic [2:0]             arsize_q,     arsize_d;
    logic [1:0]             arburst_q,    arburst_d;
    logic                   arlock_q,     arlock_d;
    logic [3:0]             arcache_q,    arcache_d;
    logic [2:0]             arprot_q,     arprot_d;
    logic [3:0]             arqos_q,      arqos_d;
    logic                   last_grant_q, last_grant_d;
    logic [CW-1:0]          cnt0_q,       cnt0_d;
    logic [CW-1:0]          cnt1_q,       cnt1_d;

    logic ar_free;
    logic elig0;
    logic elig1;
    logic grant_vld;
    logic grant_idx;
    logic r_sel;
    logic r_done;

    // Saturating outstanding-burst update; a simultaneous accept and completion cancel out.
    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                               input logic          inc,
                                               input logic          dec);
        logic [CW-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + CW'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            res = cnt - CW'(1);
        end
        return res;
    endfunction

    // Round-robin grant whenever the AR register can take a new entry.
    always_comb begin
        ar_free   = !arvalid_q || m.arready;
        elig0     = s0.arvalid && (cnt0_q < CNT_MAX);
        elig1     = s1.arvalid && (cnt1_q < CNT_MAX);
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (!reset && ar_free) begin
            if (elig0 && elig1) begin
                grant_vld = 1'b1;
                grant_idx = ~last_grant_q;
            end else if (elig0) begin
                grant_vld = 1'b1;
                grant_idx = 1'b0;
            end else if (elig1) begin
                grant_vld = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    assign s0.arready = grant_vld && !grant_idx;
    assign s1.arready = grant_vld &&  grant_idx;

    // Load the AR register on a grant, otherwise drain it once the memory port accepts.
    always_comb begin
        arvalid_d    = arvalid_q;
        arid_d       = arid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        arburst_d    = arburst_q;
        arlock_d     = arlock_q;
        arcache_d    = arcache_q;
        arprot_d     = arprot_q;
        arqos_d      = arqos_q;
        last_grant_d = last_grant_q;
        if (grant_vld) begin
            arvalid_d    = 1'b1;
            last_grant_d = grant_idx;
            if (grant_idx) begin
                arid_d    = {1'b1, s1.arid};
                araddr_d  = s1.araddr;
                arlen_d   = s1.arlen;
                arsize_d  = s1.arsize;
                arburst_d = s1.arburst;
                arlock_d  = s1.arlock;
                arcache_d = s1.arcache;
                arprot_d  = s1.arprot;
                arqos_d   = s1.arqos;
            end else begin
                arid_d    = {1'b0, s0.arid};
                araddr_d  = s0.araddr;
                arlen_d   = s0.arlen;
                arsize_d  = s0.arsize;
                arburst_d = s0.arburst;
                arlock_d  = s0.arlock;
                arcache_d = s0.arcache;
                arprot_d  = s0.arprot;
                arqos_d   = s0.arqos;
            end
        end else if (m.arready) begin
            arvalid_d = 1'b0;
        end
    end

    // Track bursts per requester: count up on accept, down on the final R beat.
    always_comb begin
        r_sel  = m.rid[S_ID_WIDTH];
        r_done = m.rvalid && m.rready && m.rlast;
        cnt0_d = cnt_next(cnt0_q, grant_vld && !grant_idx, r_done && !r_sel);
        cnt1_d = cnt_next(cnt1_q, grant_vld &&  grant_idx, r_done &&  r_sel);
    end

    // State registers; reset abandons every in-flight burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            arvalid_q    <= 1'b0;
            arid_q       <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
            arlock_q     <= 1'b0;
            arcache_q    <= '0;
            arprot_q     <= '0;
            arqos_q      <= '0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            arvalid_q    <= arvalid_d;
            arid_q       <= arid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arburst_q    <= arburst_d;
            arlock_q     <= arlock_d;
            arcache_q    <= arcache_d;
            arprot_q     <= arprot_d;
            arqos_q      <= arqos_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign m.arvalid = arvalid_q;
    assign m.arid    = arid_q;
    assign m.araddr  = araddr_q;
    assign m.arlen   = arlen_q;
    assign m.arsize  = arsize_q;
    assign m.arburst = arburst_q;
    assign m.arlock  = arlock_q;
    assign m.arcache = arcache_q;
    assign m.arprot  = arprot_q;
    assign m.arqos   = arqos_q;

    // R beats: payload broadcast, valid and backpressure steered by the ID MSB.
    always_comb begin
        s0.rid    = m.rid[S_ID_WIDTH-1:0];
        s0.rdata  = m.rdata;
        s0.rresp  = m.rresp;
        s0.rlast  = m.rlast;
        s0.rvalid = m.rvalid && !m.rid[S_ID_WIDTH];
        s1.rid    = m.rid[S_ID_WIDTH-1:0];
        s1.rdata  = m.rdata;
        s1.rresp  = m.rresp;
        s1.rlast  = m.rlast;
        s1.rvalid = m.rvalid &&  m.rid[S_ID_WIDTH];
        m.rready  = m.rid[S_ID_WIDTH] ? s1.rready : s0.rready;
    end

endmodule
